// File: rtl/mem_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_master_pkg
// Shared definitions for the mem_master burst engine:
//   state_e     - controller state encoding (IDLE, WRITE, READ, DRAIN)
//   beat_width  - width of the beat counter / req_len for a given address
//                 width (one extra bit so a full-depth burst is representable)
// -----------------------------------------------------------------------------
package mem_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int beat_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
// Burst master in front of a single-port synchronous memory. Accepts one burst
// request at a time, then issues one memory command per beat at consecutive
// (wrapping) addresses. Read data returns one cycle after rd_en and is passed
// straight through as the response.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       burst request handshake (ready only when idle)
//   req_write/addr/len        burst direction, start address, beat count
//                             (len 0 is one beat)
//   wdata_valid/ready, wdata  write-beat handshake and data
//   rsp_valid/data/last       read response, last-beat flag
//   rsp_ready                 response backpressure (MEM_MASTER_RSP_BP_EN only)
//   addr, wr_en, rd_en,
//   wr_data, rd_data          memory-side command / read data
//   busy                      controller not idle
//
// Configuration
//   MEM_MASTER_RSP_BP_EN      when defined, adds rsp_ready; responses hold
//                             until accepted and reads stall behind them.
//                             When undefined, responses are always consumed.
// -----------------------------------------------------------------------------
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [beat_width(ADDR_WIDTH)-1:0] req_len,
    input  logic                              wdata_valid,
    output logic                              wdata_ready,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic                              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              rsp_last,
`ifdef MEM_MASTER_RSP_BP_EN
    input  logic                              rsp_ready,
`endif
    output logic [ADDR_WIDTH-1:0]             addr,
    output logic                              wr_en,
    output logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              busy
);

    localparam int BEAT_W = beat_width(ADDR_WIDTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]     beats_q, beats_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_last_q, rsp_last_d;

    logic rsp_take;   // response slot is empty or is being emptied this cycle
    logic last_beat;  // the beat in flight this cycle is the final one

`ifdef MEM_MASTER_RSP_BP_EN
    assign rsp_take = !rsp_valid_q || rsp_ready;
`else
    assign rsp_take = 1'b1;
`endif

    assign last_beat = (beats_q == BEAT_W'(1));

    // Memory commands come straight from state so the first beat issues the
    // cycle after acceptance. Address/data are zeroed when no command is live.
    assign wr_en   = (state_q == ST_WRITE) && wdata_valid;
    assign rd_en   = (state_q == ST_READ) && rsp_take;
    assign addr    = (wr_en || rd_en) ? addr_q : '0;
    assign wr_data = wr_en ? wdata : '0;

    assign wdata_ready = (state_q == ST_WRITE);
    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);

    // rd_data is held by the memory until the next rd_en, and no rd_en can
    // issue while a response is stalled, so it needs no local copy.
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_valid_q ? rd_data : '0;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;

        // A response register slot is refilled by the read issued this cycle,
        // or cleared when it drains with nothing behind it.
        if (rsp_take) begin
            rsp_valid_d = rd_en;
            rsp_last_d  = rd_en && last_beat;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    beats_d = (req_len == '0) ? BEAT_W'(1) : req_len;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_en) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    beats_d = beats_q - BEAT_W'(1);
                    if (last_beat) state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    beats_d = beats_q - BEAT_W'(1);
                    if (last_beat) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only the final response can be outstanding here.
                if (rsp_take) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
// Self-checking bench for mem_master (ADDR_WIDTH=3, DATA_WIDTH=8) paired with
// a behavioural synchronous memory that resets to 8'hFF. Expected traffic is
// derived per burst from a transaction-level image of memory contents.
// MEM_MASTER_RSP_BP_EN adds the response-backpressure scenario.
// -----------------------------------------------------------------------------
module tb_mem_master;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [AW:0]   req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rsp_valid, rsp_last;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] addr;
    logic          wr_en, rd_en;
    logic [DW-1:0] wr_data, rd_data;
    logic          busy;
`ifdef MEM_MASTER_RSP_BP_EN
    logic          rsp_ready;
`endif

    mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata      (wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
`ifdef MEM_MASTER_RSP_BP_EN
        .rsp_ready  (rsp_ready),
`endif
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory block: reset fills 8'hFF, read data registered and held.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
            rd_data <= 8'hFF;
        end else begin
            if (wr_en) mem[addr] <= wr_data;
            if (rd_en) rd_data <= mem[addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observed memory/response traffic, timestamped by cycle.
    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } ev_t;
    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t rsp_q[$];

    logic rsp_acc;
`ifdef MEM_MASTER_RSP_BP_EN
    assign rsp_acc = rsp_ready;
`else
    assign rsp_acc = 1'b1;
`endif

    always @(negedge clk) begin
        if (!rst) begin
            check("cmd_exclusive", {31'b0, wr_en & rd_en}, 32'd0);
            if (wr_en) wr_q.push_back('{c: cyc, a: addr, d: wr_data, l: 1'b0});
            if (rd_en) rd_q.push_back('{c: cyc, a: addr, d: '0, l: 1'b0});
            if (rsp_valid && rsp_acc) rsp_q.push_back('{c: cyc, a: '0, d: rsp_data, l: rsp_last});
        end
    end

    // Transaction-level image of what memory must hold.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wbuf[$];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Junk on request inputs while busy; the master must ignore it.
    task automatic req_garbage();
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_len   = (AW+1)'($urandom);
    endtask

    task automatic run_write(input int a, input int len, input int gap);
        int n;
        int g;
        int exp_c[$];
        n = (len == 0) ? 1 : len;
        wr_q.delete();
        next_cycle();
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(a); req_len = (AW+1)'(len);
        wdata_valid = 1'b0;
        @(negedge clk);
        check("wr_accept_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(2, 0)) : ((i == 0) ? 0 : gap);
            repeat (g) begin
                next_cycle();
                req_garbage();
                wdata_valid = 1'b0;
                wdata = DW'($urandom);
            end
            next_cycle();
            req_garbage();
            wdata_valid = 1'b1;
            wdata = wbuf[i];
            exp_c.push_back(cyc);
        end
        next_cycle();
        req_valid = 1'b0;
        wdata_valid = 1'($urandom);
        wdata = DW'($urandom);
        @(negedge clk);
        check("wr_done_ready", {31'b0, req_ready}, 32'd1);
        check("wr_done_busy", {31'b0, busy}, 32'd0);
        wdata_valid = 1'b0;
        check("wr_beats", wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check("wr_addr", wr_q[i].a, (a + i) % DEPTH);
            check("wr_data", wr_q[i].d, wbuf[i]);
            check("wr_cycle", wr_q[i].c, exp_c[i]);
            model_mem[(a + i) % DEPTH] = wbuf[i];
        end
    endtask

    task automatic run_read(input int a, input int len);
        int n;
        int c0;
        n = (len == 0) ? 1 : len;
        rd_q.delete();
        rsp_q.delete();
        next_cycle();
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a); req_len = (AW+1)'(len);
        c0 = cyc;
        @(negedge clk);
        check("rd_accept_ready", {31'b0, req_ready}, 32'd1);
        for (int j = 0; j <= n; j++) begin
            next_cycle();
            req_garbage();
            wdata_valid = 1'($urandom);
            wdata = DW'($urandom);
            if (j == n) begin
                @(negedge clk);
                check("rd_busy_last", {31'b0, busy}, 32'd1);
            end
        end
        next_cycle();
        req_valid = 1'b0;
        wdata_valid = 1'b0;
        @(negedge clk);
        check("rd_ready_back", {31'b0, req_ready}, 32'd1);
        check("rd_ready_cycle", cyc - c0, n + 2);
        check("rd_cmds", rd_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
            check("rd_addr", rd_q[i].a, (a + i) % DEPTH);
            check("rd_cycle", rd_q[i].c - c0, i + 1);
        end
        check("rsp_count", rsp_q.size(), n);
        for (int i = 0; i < n && i < rsp_q.size(); i++) begin
            check("rsp_data", rsp_q[i].d, model_mem[(a + i) % DEPTH]);
            check("rsp_last", {31'b0, rsp_q[i].l}, (i == n - 1) ? 32'd1 : 32'd0);
            check("rsp_cycle", rsp_q[i].c - c0, i + 2);
        end
    endtask

    initial begin
        int a;
        int len;
        int c0;
        logic [DW-1:0] held;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0;
`ifdef MEM_MASTER_RSP_BP_EN
        rsp_ready = 1'b1;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cmds", {30'b0, wr_en, rd_en}, 32'd0);
        check("rst_rsp", {30'b0, rsp_valid, rsp_last}, 32'd0);
        check("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
        check("rst_addr_wdata", {21'b0, addr, wr_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Reset contents, two beats from address 0.
        run_read(0, 2);

        // Wrapping four-beat write then read back.
        wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_write(6, 4, 0);
        run_read(6, 4);

        // Three-beat write with two idle cycles between beats.
        wbuf.delete();
        repeat (3) wbuf.push_back(DW'($urandom));
        run_write(2, 3, 2);
        run_read(2, 3);

        // Length zero is a single beat.
        run_read(5, 0);

        // Randomized mix, including lengths beyond depth.
        repeat (24) begin
            a   = int'($urandom_range(DEPTH - 1, 0));
            len = int'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin
                wbuf.delete();
                repeat ((len == 0) ? 1 : len) wbuf.push_back(DW'($urandom));
                run_write(a, len, -1);
            end else begin
                run_read(a, len);
            end
        end

        // Reset in the middle of an eight-beat read after three responses.
        rsp_q.delete();
        next_cycle();
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'($urandom); req_len = 4'd8;
        c0 = cyc;
        next_cycle();
        req_valid = 1'b0;
        repeat (4) next_cycle();
        check("mid_rst_rsp_before", rsp_q.size(), 3);
        check("mid_rst_cycle", cyc - c0, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_cmds", {30'b0, wr_en, rd_en}, 32'd0);
        check("mid_rst_rsp", {22'b0, rsp_valid, rsp_last, rsp_data}, 32'd0);
        check("mid_rst_addr", {29'b0, addr}, 32'd0);
        repeat (2) next_cycle();
        rst = 1'b0;
        model_reset();
        rsp_q.delete();
        rd_q.delete();
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        repeat (10) next_cycle();
        check("post_rst_no_rsp", rsp_q.size(), 0);
        check("post_rst_no_rd", rd_q.size(), 0);
        run_read(3, 2);

`ifdef MEM_MASTER_RSP_BP_EN
        // Hold off responses for three cycles mid-read.
        wbuf = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_write(4, 4, 0);
        rsp_q.delete();
        rd_q.delete();
        next_cycle();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4; req_len = 4'd4;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        next_cycle();
        rsp_ready = 1'b0;
        @(negedge clk);
        held = rsp_data;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                next_cycle();
                @(negedge clk);
            end
            check("bp_no_rd", {31'b0, rd_en}, 32'd0);
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rsp_stable", rsp_data, held);
        end
        next_cycle();
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && busy; k++) next_cycle();
        check("bp_done", {31'b0, busy}, 32'd0);
        check("bp_rsp_count", rsp_q.size(), 4);
        check("bp_rd_count", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
            check("bp_rsp_data", rsp_q[i].d, model_mem[(4 + i) % DEPTH]);
            check("bp_rsp_last", {31'b0, rsp_q[i].l}, (i == 3) ? 32'd1 : 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 ADDR_WIDTH, 3, memory address width; memory depth is 2**ADDR_WIDTH words.
REQ-002 DATA_WIDTH, 8, memory data word width.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  burst request present.
REQ-006 req_ready  output  1  master can accept a request.
REQ-007 req_write  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  ADDR_WIDTH  burst start address.
REQ-009 req_len  input  ADDR_WIDTH+1  beat count; 0 treated as 1.
REQ-010 wdata_valid / wdata_ready / wdata  in / out / in  1 / 1 / DATA_WIDTH  write-beat handshake and data.
REQ-011 rsp_valid / rsp_data / rsp_last  output  1 / DATA_WIDTH / 1  read response, last-beat flag.
REQ-012 addr / wr_en / rd_en / wr_data  output  ADDR_WIDTH / 1 / 1 / DATA_WIDTH  memory-side command.
REQ-013 rd_data  input  DATA_WIDTH  memory read data, valid one cycle after rd_en, held until the next rd_en.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, WRITE, READ, DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept on req_valid && req_ready: latch addr into address counter, beat counter = max(req_len,1); next state WRITE or READ per req_write.
REQ-017 WRITE: wdata_ready=1; each cycle with wdata_valid: wr_en=1, wr_data=wdata, addr=counter; counter+1, beats-1; no wr_en without wdata_valid.
REQ-018 After last write beat, next state IDLE (no DRAIN).
REQ-019 READ: rd_en=1 at addr=counter each cycle a beat is issuable; counter+1, beats-1; after last rd_en go to DRAIN.
REQ-020 rsp_valid SHALL assert the cycle after each rd_en; rsp_data = rd_data; rsp_last=1 on the response of the final beat.
REQ-021 DRAIN: no memory commands; go to IDLE once the last response is delivered.
REQ-022 Latency (no backpressure): accept at cycle 0 -> first rd_en/wr_en at cycle 1; N-beat read: rsp cycles 2..N+1, req_ready high at N+2.
REQ-023 Address counter wraps modulo 2**ADDR_WIDTH; req_len > depth revisits addresses in order.
REQ-024 wr_en and rd_en SHALL never be high together; both 0 in IDLE and DRAIN.
REQ-025 req_* inputs ignored while busy; wdata_* ignored outside WRITE.

Reset
REQ-026 rst SHALL force IDLE immediately: req_ready=1 after release; busy, wr_en, rd_en, rsp_valid, rsp_last, wdata_ready = 0; addr, wr_data = 0.
REQ-027 Reset mid-burst SHALL drop the burst; no further beats or responses are produced for it.

Configuration
REQ-028 Macro MEM_MASTER_RSP_BP_EN: defined adds input rsp_ready (1 bit); undefined, responses are always consumed.
REQ-029 With macro: rsp_valid, rsp_data, rsp_last SHALL hold stable until rsp_ready; rd_en issued only if no response pending or rsp_ready=1 that cycle.
REQ-030 With macro: DRAIN exits only after the rsp_last beat is accepted; without macro, DRAIN lasts exactly one cycle.

Structure
REQ-031 Package mem_master_pkg SHALL hold the state enum and the beat-count width function (ADDR_WIDTH+1).
REQ-032 Single module; no sub-module. The bench pairs it with the team's memory block of matching parameters.

Verification (ADDR_WIDTH=3, DATA_WIDTH=8; memory reset fills 8'hFF)
REQ-033 After reset, read addr 0 len 2 -> rsp_data FF, FF; rsp_last on 2nd; req_ready back at cycle 4.
REQ-034 Write addr 6 len 4 data 11,22,33,44 -> wr_en at addrs 6,7,0,1; read addr 6 len 4 -> 11,22,33,44.
REQ-035 Write len 3 with wdata_valid low 2 cycles between beats -> no wr_en in gaps; exactly 3 wr_en pulses.
REQ-036 req_len 0 read addr 5 -> exactly one rd_en, one rsp with rsp_last=1.
REQ-037 rst asserted during 8-beat read after 3 rsp -> outputs zero that cycle; no further rsp; req_ready=1 after release.
REQ-038 Macro defined: rsp_ready low 3 cycles mid-read -> rsp_data stable, no rd_en issued; all 4 beats delivered in order.
